// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
// Mode/state encodings plus the LFSR polynomial and default seed.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BURST  = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_BOTH   = 2'd3
    } mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Right-shift Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

endpackage

// File: rtl/chan_err_lfsr.sv
// Galois LFSR with seed load and per-symbol step.
// A zero seed is replaced by 1 so the register never locks up.
module chan_err_lfsr
    import chan_err_pkg::*;
#(
    parameter int          W    = 16,
    parameter logic [W-1:0] POLY = W'(LFSR_POLY),
    parameter logic [W-1:0] SEED = W'(LFSR_SEED)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         step_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] shifted;
    logic [W-1:0] seeded;

    assign shifted = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
    assign seeded  = (seed_i == '0) ? W'(1) : seed_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else if (load_i) begin
            lfsr_q <= seeded;
        end else if (step_i) begin
            lfsr_q <= shifted;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/chan_err_inject.sv
// Channel error injector: corrupts encoder symbols in bursts or at random,
// with a symbol window, saturating statistics and one cycle of latency.
module chan_err_inject
    import chan_err_pkg::*;
#(
    parameter int W      = 2,
    parameter int CNT_W  = 16,
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [W-1:0]      sym_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  burst_start_i,
    input  logic [CNT_W-1:0]  burst_len_i,
    input  logic [W-1:0]      err_mask_i,
    input  logic [LFSR_W-1:0] rate_thresh_i,
    input  logic [CNT_W-1:0]  window_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              load_seed_i,
    input  logic              clr_i,
    output logic              valid_o,
    output logic [W-1:0]      sym_o,
    output logic [W-1:0]      err_o,
    output logic              inj_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sym_ct_o,
    output logic [CNT_W-1:0]  inj_ct_o,
    output logic [CNT_W-1:0]  bad_bit_ct_o
);

    function automatic logic [CNT_W:0] popcnt(input logic [W-1:0] v);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + (CNT_W+1)'(v[i]);
        end
        return n;
    endfunction

    state_e           state_q;
    state_e           state_d;
    logic             run;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;
    logic [CNT_W-1:0] sym_ct_q;
    logic [CNT_W-1:0] sym_ct_d;
    logic [CNT_W-1:0] inj_ct_q;
    logic [CNT_W-1:0] inj_ct_d;
    logic [CNT_W-1:0] bad_ct_q;
    logic [CNT_W-1:0] bad_ct_d;
    logic [CNT_W:0]   bad_sum;
    logic [CNT_W:0]   ph_x;
    logic [CNT_W:0]   ph_inc;
    logic [CNT_W:0]   b_lo;
    logic [CNT_W:0]   b_hi;
    logic [LFSR_W-1:0] lfsr;
    logic             burst_hit;
    logic             rand_hit;
    logic             hit;
    logic             corrupt;
    logic [W-1:0]     err;

    chan_err_lfsr #(
        .W (LFSR_W)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_seed_i),
        .seed_i  (seed_i),
        .step_i  (valid_i),
        .value_o (lfsr)
    );

    // Burst window compared one bit wider so start+len cannot wrap
    assign ph_x      = {1'b0, phase_q};
    assign ph_inc    = ph_x + (CNT_W+1)'(1);
    assign b_lo      = {1'b0, burst_start_i};
    assign b_hi      = b_lo + {1'b0, burst_len_i};
    assign burst_hit = (period_i != '0) && (ph_x >= b_lo) && (ph_x < b_hi);
    assign rand_hit  = lfsr < rate_thresh_i;

    always_comb begin
        hit = 1'b0;
        unique case (mode_e'(mode_i))
            MODE_OFF:    hit = 1'b0;
            MODE_BURST:  hit = burst_hit;
            MODE_RANDOM: hit = rand_hit;
            MODE_BOTH:   hit = burst_hit | rand_hit;
            default:     hit = 1'b0;
        endcase
    end

    assign corrupt = valid_i && !clr_i && run && hit;
    assign err     = corrupt ? err_mask_i : '0;

    assign phase_d = ((period_i == '0) || (ph_inc >= {1'b0, period_i}))
                   ? '0 : ph_inc[CNT_W-1:0];

    assign sym_ct_d = (&sym_ct_q) ? sym_ct_q : sym_ct_q + CNT_W'(1);
    assign inj_ct_d = (&inj_ct_q) ? inj_ct_q : inj_ct_q + CNT_W'(1);
    assign bad_sum  = {1'b0, bad_ct_q} + popcnt(err);
    assign bad_ct_d = bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (!clr_i && valid_i && (window_i != '0)
                    && (sym_ct_d == window_i)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (clr_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run    = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= '0;
            sym_ct_q <= '0;
            inj_ct_q <= '0;
            bad_ct_q <= '0;
        end else if (clr_i) begin
            phase_q  <= '0;
            sym_ct_q <= '0;
            inj_ct_q <= '0;
            bad_ct_q <= '0;
        end else if (valid_i) begin
            phase_q  <= phase_d;
            sym_ct_q <= sym_ct_d;
            bad_ct_q <= bad_ct_d;
            if (corrupt) begin
                inj_ct_q <= inj_ct_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o <= 1'b0;
            sym_o   <= '0;
            err_o   <= '0;
            inj_o   <= 1'b0;
        end else begin
            valid_o <= valid_i;
            sym_o   <= sym_i ^ err;
            err_o   <= err;
            inj_o   <= corrupt;
        end
    end

    assign sym_ct_o     = sym_ct_q;
    assign inj_ct_o     = inj_ct_q;
    assign bad_bit_ct_o = bad_ct_q;

endmodule

// File: tb/tb_chan_err_inject.sv
// Scoreboard bench for chan_err_inject: a reference model queues the
// expected symbol for every valid input and the DUT output is popped against it.
module tb_chan_err_inject;

    localparam int W      = 2;
    localparam int CNT_W  = 16;
    localparam int LFSR_W = 16;

    typedef struct packed {
        logic [W-1:0] sym;
        logic [W-1:0] err;
        logic         inj;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid = 1'b0;
    logic              clr = 1'b0;
    logic              load = 1'b0;
    logic [W-1:0]      sym = '0;
    logic [W-1:0]      mask = '0;
    logic [1:0]        mode = '0;
    logic [CNT_W-1:0]  period = '0;
    logic [CNT_W-1:0]  bstart = '0;
    logic [CNT_W-1:0]  blen = '0;
    logic [CNT_W-1:0]  window = '0;
    logic [LFSR_W-1:0] thresh = '0;
    logic [LFSR_W-1:0] seed = '0;

    logic              valid_o;
    logic [W-1:0]      sym_o;
    logic [W-1:0]      err_o;
    logic              inj_o;
    logic              done_o;
    logic [CNT_W-1:0]  sym_ct;
    logic [CNT_W-1:0]  inj_ct;
    logic [CNT_W-1:0]  bad_ct;

    logic              s_valid;
    logic [W-1:0]      s_sym;
    logic [W-1:0]      s_err;
    logic              s_inj;
    logic              s_done;
    logic [3:0]        s_sym_ct;
    logic [3:0]        s_inj_ct;
    logic [3:0]        s_bad_ct;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int          m_phase, m_sym, m_inj, m_bad, m_sbad, m_sinj;
    bit          m_done;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    chan_err_inject #(
        .W      (W),
        .CNT_W  (CNT_W),
        .LFSR_W (LFSR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid),
        .sym_i         (sym),
        .mode_i        (mode),
        .period_i      (period),
        .burst_start_i (bstart),
        .burst_len_i   (blen),
        .err_mask_i    (mask),
        .rate_thresh_i (thresh),
        .window_i      (window),
        .seed_i        (seed),
        .load_seed_i   (load),
        .clr_i         (clr),
        .valid_o       (valid_o),
        .sym_o         (sym_o),
        .err_o         (err_o),
        .inj_o         (inj_o),
        .done_o        (done_o),
        .sym_ct_o      (sym_ct),
        .inj_ct_o      (inj_ct),
        .bad_bit_ct_o  (bad_ct)
    );

    chan_err_inject #(
        .W      (W),
        .CNT_W  (4),
        .LFSR_W (LFSR_W)
    ) u_sat (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid),
        .sym_i         (sym),
        .mode_i        (2'd1),
        .period_i      (4'd4),
        .burst_start_i (4'd0),
        .burst_len_i   (4'd4),
        .err_mask_i    (2'b11),
        .rate_thresh_i (16'd0),
        .window_i      (4'd0),
        .seed_i        (16'd0),
        .load_seed_i   (1'b0),
        .clr_i         (clr),
        .valid_o       (s_valid),
        .sym_o         (s_sym),
        .err_o         (s_err),
        .inj_o         (s_inj),
        .done_o        (s_done),
        .sym_ct_o      (s_sym_ct),
        .inj_ct_o      (s_inj_ct),
        .bad_bit_ct_o  (s_bad_ct)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle: update the model, queue the expectation, check after the edge
    task automatic cycle();
        exp_t e;
        exp_t o;
        bit   pushed;
        bit   bh, rh, h;
        pushed = 1'b0;
        e = '0;
        if (!rst) begin
            m_phase = 0; m_sym = 0; m_inj = 0; m_bad = 0;
            m_sbad = 0; m_sinj = 0; m_done = 0;
            m_lfsr = 16'h0001;
        end else begin
            if (valid) begin
                e.sym = sym;
                pushed = 1'b1;
            end
            if (clr) begin
                m_phase = 0; m_sym = 0; m_inj = 0; m_bad = 0;
                m_sbad = 0; m_sinj = 0; m_done = 0;
            end else if (valid) begin
                bh = (period != 0) && (m_phase >= int'(bstart))
                  && (m_phase < int'(bstart) + int'(blen));
                rh = m_lfsr < thresh;
                case (mode)
                    2'd0:    h = 1'b0;
                    2'd1:    h = bh;
                    2'd2:    h = rh;
                    default: h = bh || rh;
                endcase
                if (!m_done && h) begin
                    e.inj = 1'b1;
                    e.err = mask;
                    e.sym = sym ^ mask;
                    m_inj = sat(m_inj + 1, 65535);
                    m_bad = sat(m_bad + $countones(mask), 65535);
                end
                m_sym = sat(m_sym + 1, 65535);
                if (!m_done && window != 0 && m_sym == int'(window))
                    m_done = 1'b1;
                m_phase = (period == 0 || m_phase + 1 >= int'(period))
                        ? 0 : m_phase + 1;
                m_sbad = sat(m_sbad + 2, 15);
                m_sinj = sat(m_sinj + 1, 15);
            end
            if (load) m_lfsr = (seed == 0) ? 16'h0001 : seed;
            else if (valid) m_lfsr = galois(m_lfsr);
        end
        if (pushed) q.push_back(e);
        @(posedge clk);
        #1;
        chk("valid_o", valid_o, pushed);
        if (valid_o) begin
            if (q.size() == 0) begin
                chk("queue_empty", 1, 0);
            end else begin
                o = q.pop_front();
                chk("sym_o", sym_o, o.sym);
                chk("err_o", err_o, o.err);
                chk("inj_o", inj_o, o.inj);
            end
        end
        chk("done_o", done_o, m_done);
        chk("sym_ct", sym_ct, m_sym);
        chk("inj_ct", inj_ct, m_inj);
        chk("bad_ct", bad_ct, m_bad);
        chk("sat_bad_ct", s_bad_ct, m_sbad);
        chk("sat_inj_ct", s_inj_ct, m_sinj);
    endtask

    initial begin
        rst = 1'b0;
        valid = 1'b1;
        sym = 2'b01;
        cycle();
        cycle();
        chk("rst_valid", valid_o, 0);
        chk("rst_sym", sym_o, 0);
        chk("rst_done", done_o, 0);
        rst = 1'b1;

        // OFF: clean pass-through with gaps
        mode = 2'd0;
        mask = 2'b11;
        for (int i = 0; i < 110; i++) begin
            valid = (i % 11) != 10;
            sym = W'($urandom);
            cycle();
        end
        chk("off_sym_ct", sym_ct, 100);
        chk("off_inj_ct", inj_ct, 0);
        chk("off_bad_ct", bad_ct, 0);

        // BURST with window 256
        valid = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        mode = 2'd1;
        period = 32;
        bstart = 27;
        blen = 4;
        mask = 2'b10;
        window = 256;
        for (int i = 0; i < 256; i++) begin
            valid = 1'b1;
            sym = W'($urandom);
            cycle();
            chk("burst_phase", inj_o, ((i % 32) >= 27) && ((i % 32) <= 30));
        end
        chk("burst_inj_ct", inj_ct, 32);
        chk("burst_bad_ct", bad_ct, 32);
        chk("burst_done", done_o, 1);
        for (int i = 0; i < 20; i++) begin
            sym = W'($urandom);
            cycle();
            chk("done_clean", err_o, 0);
        end
        chk("done_sym_ct", sym_ct, 276);

        // RANDOM: threshold 0 then all-ones
        valid = 1'b0;
        clr = 1'b1;
        load = 1'b1;
        seed = 16'd1;
        cycle();
        clr = 1'b0;
        load = 1'b0;
        mode = 2'd2;
        window = 0;
        mask = 2'b01;
        thresh = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1;
            sym = W'($urandom);
            cycle();
        end
        chk("rand0_inj_ct", inj_ct, 0);
        thresh = 16'hFFFF;
        load = 1'b1;
        seed = 16'd0;
        for (int i = 0; i < 64; i++) begin
            sym = W'($urandom);
            cycle();
            load = 1'b0;
        end
        chk("rand_ff_inj_ct", inj_ct, m_inj);

        // clr on the 100th symbol of a burst run
        valid = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        mode = 2'd1;
        period = 8;
        bstart = 0;
        blen = 4;
        mask = 2'b11;
        for (int i = 0; i < 99; i++) begin
            valid = 1'b1;
            sym = W'($urandom);
            cycle();
        end
        clr = 1'b1;
        sym = 2'b10;
        cycle();
        clr = 1'b0;
        chk("clr_sym_ct", sym_ct, 0);
        chk("clr_inj_ct", inj_ct, 0);
        chk("clr_clean", err_o, 0);
        chk("clr_sym", sym_o, 2'b10);
        cycle();
        chk("phase_restart", inj_o, 1);
        for (int i = 0; i < 9; i++) begin
            sym = W'($urandom);
            cycle();
        end
        chk("sat_bad_15", s_bad_ct, 15);

        // Reset mid-burst, then random run from the reset seed
        rst = 1'b0;
        cycle();
        chk("mrst_valid", valid_o, 0);
        chk("mrst_inj", inj_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_sym_ct", sym_ct, 0);
        rst = 1'b1;
        mode = 2'd2;
        thresh = 16'h8000;
        for (int i = 0; i < 32; i++) begin
            sym = W'($urandom);
            cycle();
        end
        valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
